rx_pkt_dequeue: RTL and testbench

Packet-interface read stage on the 156.25 MHz side of the receive path. It pops 72-bit entries (8-bit status plus 64-bit data) from the clock-crossing RX data FIFO and presents them as a registered packet stream to the user. It also:
- enforces SOP/EOP framing,
- discards orphaned words after an overflow,
- closes frames truncated by a missing EOP.

---
 rtl/rx_pkt_dequeue_pkg.sv | 23 ++
 rtl/rx_stat_counter.sv | 24 ++
 rtl/rx_pkt_dequeue.sv | 178 +++++++++++++++++
 tb/tb_rx_pkt_dequeue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkt_dequeue_pkg.sv
// Shared RX FIFO status layout and dequeue state encoding.
// The status bit positions are common with the RX write-side framer.
package rx_pkt_dequeue_pkg;

  localparam int RXSTATUS_W      = 8;
  localparam int RXDATA_W        = 64;
  localparam int RXSTATUS_SOP    = 7;
  localparam int RXSTATUS_EOP    = 6;
  localparam int RXSTATUS_ERR    = 5;
  localparam int RXSTATUS_MOD_HI = 2;
  localparam int RXSTATUS_MOD_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_TRUNC = 2'd2
  } rx_deq_state_t;

  function automatic logic [2:0] status_mod(input logic [RXSTATUS_W-1:0] status);
    return status[RXSTATUS_MOD_HI:RXSTATUS_MOD_LO];
  endfunction

endpackage

// File: rtl/rx_stat_counter.sv
// Saturating statistics counter with synchronous clear.
module rx_stat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Count up on inc, hold at all-ones; clear wins over inc.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/rx_pkt_dequeue.sv
// RX packet read stage: pops the RX data FIFO and presents a registered packet stream.
// Optional statistics counters are built when RX_DEQUEUE_STATS_EN is defined.
module rx_pkt_dequeue
  import rx_pkt_dequeue_pkg::*;
#(
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk_156m25,
  input  logic                  reset_156m25,
  input  logic [RXDATA_W-1:0]   rxdfifo_rdata,
  input  logic [RXSTATUS_W-1:0] rxdfifo_rstatus,
  input  logic                  rxdfifo_rempty,
  input  logic                  rxdfifo_ralmost_empty,
  output logic                  rxdfifo_ren,
  input  logic                  pkt_rx_ren,
  output logic                  pkt_rx_avail,
  output logic [RXDATA_W-1:0]   pkt_rx_data,
  output logic                  pkt_rx_val,
  output logic                  pkt_rx_sop,
  output logic                  pkt_rx_eop,
  output logic [2:0]            pkt_rx_mod,
  output logic                  pkt_rx_err
`ifdef RX_DEQUEUE_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_frames,
  output logic [STAT_WIDTH-1:0] stat_err_frames,
  output logic [STAT_WIDTH-1:0] stat_drop_words
`endif
);

  rx_deq_state_t state_r;
  logic          head_sop_s;
  logic          head_eop_s;
  logic          head_err_s;
  logic [2:0]    head_mod_s;
  logic          pop_s;
  logic          avail_next_s;
  logic          unused_status_bits;

  assign head_sop_s         = rxdfifo_rstatus[RXSTATUS_SOP];
  assign head_eop_s         = rxdfifo_rstatus[RXSTATUS_EOP];
  assign head_err_s         = rxdfifo_rstatus[RXSTATUS_ERR];
  assign head_mod_s         = status_mod(rxdfifo_rstatus);
  assign unused_status_bits = ^rxdfifo_rstatus[4:3];

  // Pop decision; orphans drain on their own, gated off during reset so no word is lost.
  always_comb begin
    pop_s = 1'b0;
    if (reset_156m25 || rxdfifo_rempty) begin
      pop_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:  pop_s = !head_sop_s || pkt_rx_ren;
        ST_DATA:  pop_s = !head_sop_s && pkt_rx_ren;
        ST_TRUNC: pop_s = 1'b0;
        default:  pop_s = 1'b0;
      endcase
    end
  end

  assign rxdfifo_ren = pop_s;

  // Advertise data only when the next word can go out without starving mid-frame.
  always_comb begin
    avail_next_s = 1'b0;
    if (state_r == ST_TRUNC) begin
      avail_next_s = 1'b1;
    end else if (!rxdfifo_rempty && ((state_r == ST_IDLE && head_sop_s) || state_r == ST_DATA)) begin
      avail_next_s = !rxdfifo_ralmost_empty || head_eop_s;
    end else begin
      avail_next_s = 1'b0;
    end
  end

  // Framing FSM with registered packet outputs; flags are zero whenever val is low.
  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state_r      <= ST_IDLE;
      pkt_rx_avail <= 1'b0;
      pkt_rx_val   <= 1'b0;
      pkt_rx_sop   <= 1'b0;
      pkt_rx_eop   <= 1'b0;
      pkt_rx_err   <= 1'b0;
      pkt_rx_mod   <= 3'd0;
      pkt_rx_data  <= 64'd0;
    end else begin
      pkt_rx_avail <= avail_next_s;
      pkt_rx_val   <= 1'b0;
      pkt_rx_sop   <= 1'b0;
      pkt_rx_eop   <= 1'b0;
      pkt_rx_err   <= 1'b0;
      pkt_rx_mod   <= 3'd0;
      pkt_rx_data  <= 64'd0;
      case (state_r)
        ST_IDLE: begin
          if (pop_s && head_sop_s) begin
            pkt_rx_val  <= 1'b1;
            pkt_rx_sop  <= 1'b1;
            pkt_rx_data <= rxdfifo_rdata;
            if (head_eop_s) begin
              pkt_rx_eop <= 1'b1;
              pkt_rx_err <= head_err_s;
              pkt_rx_mod <= head_mod_s;
            end else begin
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (!rxdfifo_rempty && head_sop_s) begin
            state_r <= ST_TRUNC;
          end else if (pop_s) begin
            pkt_rx_val  <= 1'b1;
            pkt_rx_data <= rxdfifo_rdata;
            if (head_eop_s) begin
              pkt_rx_eop <= 1'b1;
              pkt_rx_err <= head_err_s;
              pkt_rx_mod <= head_mod_s;
              state_r    <= ST_IDLE;
            end
          end
        end
        ST_TRUNC: begin
          // Synthetic errored EOP closes the frame; the waiting SOP stays in the FIFO.
          if (pkt_rx_ren) begin
            pkt_rx_val <= 1'b1;
            pkt_rx_eop <= 1'b1;
            pkt_rx_err <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef RX_DEQUEUE_STATS_EN
  logic frame_done_s;
  logic frame_err_s;
  logic drop_word_s;

  // Events that will appear on the outputs after this edge.
  always_comb begin
    frame_done_s = 1'b0;
    frame_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        frame_done_s = pop_s && head_sop_s && head_eop_s;
        frame_err_s  = frame_done_s && head_err_s;
      end
      ST_DATA: begin
        frame_done_s = pop_s && head_eop_s;
        frame_err_s  = frame_done_s && head_err_s;
      end
      ST_TRUNC: begin
        frame_done_s = pkt_rx_ren;
        frame_err_s  = pkt_rx_ren;
      end
      default: begin
        frame_done_s = 1'b0;
        frame_err_s  = 1'b0;
      end
    endcase
  end

  assign drop_word_s = pop_s && (state_r == ST_IDLE) && !head_sop_s;

  rx_stat_counter #(.WIDTH(STAT_WIDTH)) u_stat_frames (
    .clk(clk_156m25), .clear(reset_156m25), .inc(frame_done_s), .count(stat_frames));
  rx_stat_counter #(.WIDTH(STAT_WIDTH)) u_stat_err_frames (
    .clk(clk_156m25), .clear(reset_156m25), .inc(frame_err_s), .count(stat_err_frames));
  rx_stat_counter #(.WIDTH(STAT_WIDTH)) u_stat_drop_words (
    .clk(clk_156m25), .clear(reset_156m25), .inc(drop_word_s), .count(stat_drop_words));
`else
  localparam int unused_stat_width = STAT_WIDTH;
`endif

endmodule

// File: tb/tb_rx_pkt_dequeue.sv
// Self-checking bench for rx_pkt_dequeue: vector table, directed corner sequences, random run vs model.
module tb_rx_pkt_dequeue;

  localparam int SW        = 4;
  localparam int AE_THRESH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] rdata = 64'd0;
  logic [7:0]  rstatus = 8'd0;
  logic        rempty = 1'b1;
  logic        ralmost_empty = 1'b1;
  logic        fifo_ren;
  logic        ren_in = 1'b0;
  logic        avail, val, sop, eop, err;
  logic [2:0]  mod;
  logic [63:0] data;
`ifdef RX_DEQUEUE_STATS_EN
  logic [SW-1:0] st_frames, st_errf, st_drop;
`endif

  always #3 clk = ~clk;

  rx_pkt_dequeue #(.STAT_WIDTH(SW)) dut (
    .clk_156m25(clk), .reset_156m25(reset),
    .rxdfifo_rdata(rdata), .rxdfifo_rstatus(rstatus),
    .rxdfifo_rempty(rempty), .rxdfifo_ralmost_empty(ralmost_empty),
    .rxdfifo_ren(fifo_ren), .pkt_rx_ren(ren_in), .pkt_rx_avail(avail),
    .pkt_rx_data(data), .pkt_rx_val(val), .pkt_rx_sop(sop), .pkt_rx_eop(eop),
    .pkt_rx_mod(mod), .pkt_rx_err(err)
`ifdef RX_DEQUEUE_STATS_EN
    , .stat_frames(st_frames), .stat_err_frames(st_errf), .stat_drop_words(st_drop)
`endif
  );

  int tests = 0;
  int fails = 0;

  logic [71:0] fifo_q[$];

  // Reference model: expected outputs for the next cycle and running event counts.
  logic        m_in_frame = 1'b0, m_trunc = 1'b0;
  logic        m_val = 1'b0, m_sop = 1'b0, m_eop = 1'b0, m_err = 1'b0, m_avail = 1'b0;
  logic [2:0]  m_mod = 3'd0;
  logic [63:0] m_data = 64'd0;
  int          m_frames = 0, m_errf = 0, m_drop = 0;

  logic [7:0]  obs_out;
  logic        obs_ren;

  int gen_left = 0;
  logic gen_trunc = 1'b0;

  typedef struct packed {
    logic [1:0] load;
    logic       ren;
    logic       fren;
    logic [7:0] out;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input int v);
    int mx;
    mx = (1 << SW) - 1;
    return (v > mx) ? 64'(mx) : 64'(v);
  endfunction

  task automatic push(input logic [7:0] st);
    fifo_q.push_back({st, $urandom(), $urandom()});
  endtask

  task automatic deliver(input logic [71:0] w, input logic first);
    m_val  = 1'b1;
    m_sop  = first;
    m_data = w[63:0];
    if (w[70]) begin
      m_eop = 1'b1;
      m_err = w[69];
      m_mod = w[66:64];
      m_frames++;
      if (w[69]) m_errf++;
    end
  endtask

  task automatic model_step(input logic rst, input logic ren, input logic empty,
                            input logic ae, input logic [71:0] head, output logic pop);
    logic h_sop, h_eop;
    h_sop = head[71];
    h_eop = head[70];
    pop = 1'b0;
    {m_val, m_sop, m_eop, m_err} = 4'b0000;
    m_mod = 3'd0;
    m_data = 64'd0;
    if (rst) begin
      m_in_frame = 1'b0; m_trunc = 1'b0; m_avail = 1'b0;
      m_frames = 0; m_errf = 0; m_drop = 0;
    end else begin
      m_avail = m_trunc || (!empty && (m_in_frame || h_sop) && (!ae || h_eop));
      if (m_trunc) begin
        if (ren) begin
          m_val = 1'b1; m_eop = 1'b1; m_err = 1'b1; m_trunc = 1'b0;
          m_frames++; m_errf++;
        end
      end else if (!m_in_frame) begin
        if (!empty && !h_sop) begin
          pop = 1'b1; m_drop++;
        end else if (!empty && ren) begin
          pop = 1'b1; deliver(head, 1'b1);
          m_in_frame = !h_eop;
        end
      end else if (!empty) begin
        if (h_sop) begin
          m_trunc = 1'b1; m_in_frame = 1'b0;
        end else if (ren) begin
          pop = 1'b1; deliver(head, 1'b0);
          if (h_eop) m_in_frame = 1'b0;
        end
      end
    end
  endtask

  // One clock: check visible outputs, drive the FIFO head and ren, check the pop strobe.
  task automatic cycle(input logic rst, input logic ren);
    logic [71:0] head;
    logic empty, ae, pop_exp;
    @(negedge clk);
    obs_out = {val, sop, eop, err, mod, avail};
    check("outputs", 64'(obs_out), 64'({m_val, m_sop, m_eop, m_err, m_mod, m_avail}));
    if (m_val) check("data", data, m_data);
`ifdef RX_DEQUEUE_STATS_EN
    check("stat_frames", 64'(st_frames), sat(m_frames));
    check("stat_err_frames", 64'(st_errf), sat(m_errf));
    check("stat_drop_words", 64'(st_drop), sat(m_drop));
`endif
    empty = (fifo_q.size() == 0);
    ae    = (fifo_q.size() <= AE_THRESH);
    head  = empty ? {8'($urandom()), $urandom(), $urandom()} : fifo_q[0];
    reset = rst; ren_in = ren; rempty = empty; ralmost_empty = ae;
    rstatus = head[71:64]; rdata = head[63:0];
    #1;
    model_step(rst, ren, empty, ae, head, pop_exp);
    obs_ren = fifo_ren;
    check("fifo_ren", 64'(fifo_ren), 64'(pop_exp));
    if (fifo_ren === 1'b1 && !empty) void'(fifo_q.pop_front());
  endtask

  task automatic gen_push();
    logic [7:0] st;
    st = 8'($urandom());
    if (gen_left == 0) begin
      if ($urandom_range(0, 7) == 0) begin
        st[7] = 1'b0;
      end else begin
        gen_left  = $urandom_range(1, 5);
        gen_trunc = ($urandom_range(0, 7) == 0);
        st[7] = 1'b1;
        gen_left--;
        st[6] = (gen_left == 0) && !gen_trunc;
      end
    end else begin
      st[7] = 1'b0;
      gen_left--;
      st[6] = (gen_left == 0) && !gen_trunc;
    end
    push(st);
  endtask

  initial begin
    // {load, ren, expected fifo_ren, expected {val,sop,eop,err,mod,avail}}
    vecs[0]  = '{2'd1, 1'b1, 1'b1, 8'h00};
    vecs[1]  = '{2'd0, 1'b1, 1'b1, 8'hC1};
    vecs[2]  = '{2'd0, 1'b1, 1'b1, 8'h80};
    vecs[3]  = '{2'd0, 1'b1, 1'b0, 8'hA7};
    vecs[4]  = '{2'd0, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{2'd2, 1'b1, 1'b1, 8'h00};
    vecs[6]  = '{2'd0, 1'b1, 1'b1, 8'hC1};
    vecs[7]  = '{2'd0, 1'b1, 1'b0, 8'h81};
    vecs[8]  = '{2'd0, 1'b1, 1'b0, 8'h00};
    vecs[9]  = '{2'd0, 1'b1, 1'b1, 8'hB1};
    vecs[10] = '{2'd0, 1'b1, 1'b1, 8'hC0};
    vecs[11] = '{2'd0, 1'b1, 1'b0, 8'hA1};
    vecs[12] = '{2'd0, 1'b0, 1'b0, 8'h00};

    repeat (2) @(posedge clk);
    cycle(1'b1, 1'b0);

    // 3-word frame, then missing-EOP truncation.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].load == 2'd1) begin
        push(8'h80); push(8'h00); push(8'h43);
      end else if (vecs[i].load == 2'd2) begin
        push(8'h80); push(8'h00); push(8'h80); push(8'h40);
      end
      cycle(1'b0, vecs[i].ren);
      check($sformatf("vec%0d_out", i), 64'(obs_out), 64'(vecs[i].out));
      check($sformatf("vec%0d_ren", i), 64'(obs_ren), 64'(vecs[i].fren));
    end

    // Orphans drain without the user; the SOP then waits with avail high.
    cycle(1'b1, 1'b0);
    push(8'h00); push(8'h00); push(8'h40);
    push(8'h80); push(8'h00); push(8'h00); push(8'h41);
    repeat (6) cycle(1'b0, 1'b0);
    check("orphan_left", 64'(fifo_q.size()), 64'd4);
    check("orphan_avail", 64'(obs_out[0]), 64'd1);
`ifdef RX_DEQUEUE_STATS_EN
    check("orphan_drop_cnt", 64'(st_drop), 64'd3);
`endif
    repeat (6) cycle(1'b0, 1'b1);

    // Underflow mid-frame: bubble, no pop, frame resumes cleanly.
    cycle(1'b1, 1'b0);
    push(8'h80); push(8'h00);
    repeat (2) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    check("underflow_ren", 64'(obs_ren), 64'd0);
    cycle(1'b0, 1'b1);
    check("underflow_bubble", 64'(obs_out[7]), 64'd0);
    push(8'h00); push(8'h43);
    repeat (3) cycle(1'b0, 1'b1);
    check("underflow_eop", 64'(obs_out[7:1]), 64'({1'b1, 1'b0, 1'b1, 1'b0, 3'd3}));

    // One-cycle reset mid-frame; rest of the frame is orphaned, next frame intact.
    cycle(1'b1, 1'b0);
    push(8'h80); push(8'h00); push(8'h00); push(8'h40); push(8'h80); push(8'h40);
    repeat (2) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    check("rst_mid_out", 64'(obs_out), 64'd0);
    repeat (6) cycle(1'b0, 1'b1);
    check("rst_mid_drained", 64'(fifo_q.size()), 64'd0);

    // Errored EOP with mod 0.
    cycle(1'b1, 1'b0);
    push(8'h80); push(8'h60);
    repeat (3) cycle(1'b0, 1'b1);
    check("err_eop", 64'(obs_out[7:1]), 64'({1'b1, 1'b0, 1'b1, 1'b1, 3'd0}));

    // 16 single-word frames saturate a 4-bit frame counter.
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) push(8'hC0);
    repeat (18) cycle(1'b0, 1'b1);
`ifdef RX_DEQUEUE_STATS_EN
    check("sat_frames", 64'(st_frames), 64'hF);
`endif

    // Random traffic against the model.
    cycle(1'b1, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      if (fifo_q.size() < 16 && $urandom_range(0, 1) == 1) gen_push();
      cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
